fp_alu_pipe: RTL and testbench

- Pipelined, parametrised successor to the combinational FP add/mul ALU.
- Operates on IEEE-754-style binary floats of configurable exponent/mantissa width.
- Performs add, subtract or multiply with round-to-nearest-even and exception flags.
- Three-stage pipeline with valid/ready handshakes on input and output; sits between the operand issue logic and the result writeback/collector.

---
 rtl/fp_alu_pipe.sv | 262 ++++++++++++++++++++++++++
 tb/tb_fp_alu_pipe.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_alu_pipe.sv
// rtl/fp_alu_pipe.sv - three-stage pipelined FP add/sub/mul, round-to-nearest-even, with exception flags
module fp_alu_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int XLEN  = EXP_W + MAN_W + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [1:0]      op,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            overflow,
  output logic            underflow,
  output logic            invalid,
  output logic            zero
);

  localparam int M   = MAN_W + 1;
  localparam int W   = MAN_W + 4;
  localparam int PW  = 2 * M;
  localparam int LZW = $clog2(W + 2);
  localparam int EW2 = EXP_W + LZW + 2;

  localparam logic [XLEN-1:0]       QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [EXP_W-1:0]      DIFF_MAX = EXP_W'(MAN_W + 3);
  localparam logic signed [EW2-1:0] BIAS     = EW2'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW2-1:0] EMAX     = EW2'((1 << EXP_W) - 1);
  localparam logic signed [EW2-1:0] ONE      = EW2'(1);
  localparam logic signed [EW2-1:0] EZERO    = '0;

  logic adv;
  assign adv      = !(out_valid && !out_ready);
  assign in_ready = adv;

  // ---------------- stage 1: unpack / classify / swap ----------------
  logic             a_s, b_s, b_se, mul_s, is_mul;
  logic [EXP_W-1:0] a_e, b_e;
  logic [MAN_W-1:0] a_f, b_f;
  logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [M-1:0]     a_m, b_m;

  assign a_s    = in1[XLEN-1];
  assign b_s    = in2[XLEN-1];
  assign a_e    = in1[XLEN-2 -: EXP_W];
  assign b_e    = in2[XLEN-2 -: EXP_W];
  assign a_f    = in1[MAN_W-1:0];
  assign b_f    = in2[MAN_W-1:0];
  assign is_mul = (op == 2'b10);
  assign b_se   = b_s ^ (op == 2'b01);
  assign mul_s  = a_s ^ b_s;

  assign a_zero = (a_e == '0);
  assign b_zero = (b_e == '0);
  assign a_inf  = (a_e == '1) && (a_f == '0);
  assign b_inf  = (b_e == '1) && (b_f == '0);
  assign a_nan  = (a_e == '1) && (a_f != '0);
  assign b_nan  = (b_e == '1) && (b_f != '0);
  // Subnormals lose their fraction here, so they behave as signed zeros downstream.
  assign a_m    = a_zero ? '0 : {1'b1, a_f};
  assign b_m    = b_zero ? '0 : {1'b1, b_f};
  assign swap   = !is_mul && ({b_e, b_m} > {a_e, a_m});

  logic             sp, sp_inv, hi_s;
  logic [XLEN-1:0]  sp_res;
  logic [EXP_W-1:0] hi_e, lo_e;
  logic [M-1:0]     hi_m, lo_m;

  always_comb begin
    sp     = 1'b0;
    sp_inv = 1'b0;
    sp_res = '0;
    if (a_nan || b_nan) begin
      sp = 1'b1; sp_inv = 1'b1; sp_res = QNAN;
    end else if (is_mul) begin
      if ((a_inf && b_zero) || (b_inf && a_zero)) begin
        sp = 1'b1; sp_inv = 1'b1; sp_res = QNAN;
      end else if (a_inf || b_inf) begin
        sp = 1'b1; sp_res = {mul_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (a_zero || b_zero) begin
        sp = 1'b1; sp_res = {mul_s, {(XLEN-1){1'b0}}};
      end
    end else if (a_inf && b_inf) begin
      sp = 1'b1;
      if (a_s != b_se) begin
        sp_inv = 1'b1; sp_res = QNAN;
      end else begin
        sp_res = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end
    end else if (a_inf) begin
      sp = 1'b1; sp_res = {a_s, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (b_inf) begin
      sp = 1'b1; sp_res = {b_se, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  always_comb begin
    if (swap) begin
      hi_s = b_se; hi_e = b_e; hi_m = b_m; lo_e = a_e; lo_m = a_m;
    end else begin
      hi_s = a_s;  hi_e = a_e; hi_m = a_m; lo_e = b_e; lo_m = b_m;
    end
  end

  logic             v1, s1_sp, s1_sp_inv, s1_mul, s1_sign, s1_eff_sub;
  logic [XLEN-1:0]  s1_sp_res;
  logic [EXP_W-1:0] s1_e_hi, s1_e_lo, s1_diff;
  logic [M-1:0]     s1_m_hi, s1_m_lo;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1 <= 1'b0; s1_sp <= 1'b0; s1_sp_inv <= 1'b0; s1_sp_res <= '0;
      s1_mul <= 1'b0; s1_sign <= 1'b0; s1_eff_sub <= 1'b0;
      s1_e_hi <= '0; s1_e_lo <= '0; s1_diff <= '0; s1_m_hi <= '0; s1_m_lo <= '0;
    end else if (adv) begin
      v1         <= in_valid;
      s1_sp      <= sp;
      s1_sp_inv  <= sp_inv;
      s1_sp_res  <= sp_res;
      s1_mul     <= is_mul;
      s1_sign    <= is_mul ? mul_s : hi_s;
      s1_eff_sub <= !is_mul && (a_s != b_se);
      s1_e_hi    <= hi_e;
      s1_e_lo    <= lo_e;
      s1_diff    <= hi_e - lo_e;
      s1_m_hi    <= hi_m;
      s1_m_lo    <= lo_m;
    end
  end

  // ---------------- stage 2: align+add / multiply ----------------
  logic [W-1:0]            ext_hi, ext_lo, lost, aligned;
  logic [W:0]              sum2;
  logic [PW-1:0]           prod2;
  logic signed [EW2-1:0]   e_hi_x, e_lo_x, exp2;

  assign ext_hi = {s1_m_hi, 3'b000};
  assign ext_lo = {s1_m_lo, 3'b000};
  assign lost   = ext_lo & ~({W{1'b1}} << s1_diff);
  // Bit 0 of the aligned operand doubles as the sticky bit for everything shifted past it.
  assign aligned = (s1_diff > DIFF_MAX) ? {{(W-1){1'b0}}, |s1_m_lo}
                                        : ((ext_lo >> s1_diff) | {{(W-1){1'b0}}, |lost});
  assign sum2   = s1_eff_sub ? ({1'b0, ext_hi} - {1'b0, aligned})
                             : ({1'b0, ext_hi} + {1'b0, aligned});
  assign prod2  = PW'(s1_m_hi) * PW'(s1_m_lo);
  assign e_hi_x = EW2'(s1_e_hi);
  assign e_lo_x = EW2'(s1_e_lo);
  assign exp2   = s1_mul ? (e_hi_x + e_lo_x - BIAS) : e_hi_x;

  logic                  v2, s2_sp, s2_sp_inv, s2_mul, s2_sign, s2_eff_sub;
  logic [XLEN-1:0]       s2_sp_res;
  logic signed [EW2-1:0] s2_exp;
  logic [W:0]            s2_sum;
  logic [PW-1:0]         s2_prod;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2 <= 1'b0; s2_sp <= 1'b0; s2_sp_inv <= 1'b0; s2_sp_res <= '0;
      s2_mul <= 1'b0; s2_sign <= 1'b0; s2_eff_sub <= 1'b0;
      s2_exp <= '0; s2_sum <= '0; s2_prod <= '0;
    end else if (adv) begin
      v2         <= v1;
      s2_sp      <= s1_sp;
      s2_sp_inv  <= s1_sp_inv;
      s2_sp_res  <= s1_sp_res;
      s2_mul     <= s1_mul;
      s2_sign    <= s1_sign;
      s2_eff_sub <= s1_eff_sub;
      s2_exp     <= exp2;
      s2_sum     <= sum2;
      s2_prod    <= prod2;
    end
  end

  // ---------------- stage 3: normalise / round / pack ----------------
  logic [LZW-1:0]        lz;
  logic [W:0]            sn;
  logic signed [EW2-1:0] lz_x, e_pre, e_r;
  logic [M-1:0]          mant;
  logic [M:0]            mant_r;
  logic [MAN_W-1:0]      frac_r;
  logic                  g_bit, st_bit, rnd;

  always_comb begin
    lz = LZW'(W + 1);
    for (int i = 0; i <= W; i++) begin
      if (s2_sum[i]) lz = LZW'(W - i);
    end
  end

  assign sn   = s2_sum << lz;
  assign lz_x = EW2'(lz);

  always_comb begin
    if (s2_mul) begin
      if (s2_prod[PW-1]) begin
        mant = s2_prod[PW-1:M]; g_bit = s2_prod[M-1]; st_bit = |s2_prod[M-2:0];
        e_pre = s2_exp + ONE;
      end else begin
        mant = s2_prod[PW-2:M-1]; g_bit = s2_prod[M-2]; st_bit = |s2_prod[M-3:0];
        e_pre = s2_exp;
      end
    end else begin
      mant = sn[W:4]; g_bit = sn[3]; st_bit = |sn[2:0];
      e_pre = s2_exp + ONE - lz_x;
    end
  end

  assign rnd    = g_bit && (st_bit || mant[0]);
  assign mant_r = {1'b0, mant} + {{M{1'b0}}, rnd};
  assign frac_r = mant_r[M] ? mant_r[MAN_W:1] : mant_r[MAN_W-1:0];
  assign e_r    = e_pre + (mant_r[M] ? ONE : EZERO);

  logic [XLEN-1:0] r_res;
  logic            r_ovf, r_unf, r_inv;

  always_comb begin
    r_res = '0;
    r_ovf = 1'b0;
    r_unf = 1'b0;
    r_inv = 1'b0;
    if (s2_sp) begin
      r_res = s2_sp_res;
      r_inv = s2_sp_inv;
    end else if (!s2_mul && (s2_sum == '0)) begin
      // Exact cancellation is +0; like-signed zeros keep their sign.
      r_res = {s2_sign && !s2_eff_sub, {(XLEN-1){1'b0}}};
    end else if (e_r >= EMAX) begin
      r_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      r_ovf = 1'b1;
    end else if (e_r <= EZERO) begin
      r_res = {s2_sign, {(XLEN-1){1'b0}}};
      r_unf = 1'b1;
    end else begin
      r_res = {s2_sign, e_r[EXP_W-1:0], frac_r};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0; result <= '0;
      overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0; zero <= 1'b0;
    end else if (adv) begin
      out_valid <= v2;
      if (v2) begin
        result    <= r_res;
        overflow  <= r_ovf;
        underflow <= r_unf;
        invalid   <= r_inv;
        zero      <= (r_res[XLEN-2:0] == '0);
      end else begin
        result <= '0;
        overflow <= 1'b0; underflow <= 1'b0; invalid <= 1'b0; zero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fp_alu_pipe.sv
// tb/tb_fp_alu_pipe.sv - scoreboard bench for fp_alu_pipe (binary32 configuration)
module tb_fp_alu_pipe;

  logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in1, in2, result;
  logic [1:0]  op;
  logic        overflow, underflow, invalid, zero;

  fp_alu_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow),
    .invalid(invalid), .zero(zero)
  );

  typedef struct {
    logic [31:0] res;
    logic [3:0]  fl;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   delivered = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flags are packed as {overflow, underflow, invalid, zero}.
  always begin
    @(negedge clk);
    #3;
    if (!rst && out_valid && out_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL unexpected_output result=%h required=none", result);
      end else begin
        mon_e = sb.pop_front();
        delivered++;
        if ({result, overflow, underflow, invalid, zero} !== {mon_e.res, mon_e.fl}) begin
          bad++;
          $display("FAIL result got=%h flags=%b required=%h flags=%b",
                   result, {overflow, underflow, invalid, zero}, mon_e.res, mon_e.fl);
        end
        if (mon_e.lat) begin
          total++;
          if ((cyc - mon_e.acc) !== 3) begin
            bad++;
            $display("FAIL latency got=%0d required=3 result=%h", cyc - mon_e.acc, mon_e.res);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic issue(input logic [31:0] a, input logic [1:0] o, input logic [31:0] b,
                       input logic [31:0] r, input logic [3:0] fl, input bit lat);
    exp_t e;
    int   n;
    @(negedge clk);
    in1 = a; in2 = b; op = o; in_valid = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("FAIL issue_timeout in_ready=%b required=1", in_ready);
      in_valid = 1'b0;
    end else begin
      e.res = r; e.fl = fl; e.acc = cyc; e.lat = lat;
      sb.push_back(e);
      @(posedge clk);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b required=0", out_valid); end
    total++;
    if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h required=00000000", result); end
    total++;
    if ({overflow, underflow, invalid, zero} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags got=%b required=0000", {overflow, underflow, invalid, zero});
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b required=1", in_ready); end
    repeat (3) begin
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL idle_out_valid got=%b required=0", out_valid); end
    end
  endtask

  task automatic test_add_sub();
    issue(32'h3FC00000, 2'b00, 32'h3FC00000, 32'h40400000, 4'b0000, 1);
    issue(32'h3F800000, 2'b00, 32'hBF800000, 32'h00000000, 4'b0001, 1);
    issue(32'h41200000, 2'b01, 32'h41200000, 32'h00000000, 4'b0001, 1);
    issue(32'h40400000, 2'b01, 32'h3F800000, 32'h40000000, 4'b0000, 1);
    issue(32'h3F800000, 2'b11, 32'h3F800000, 32'h40000000, 4'b0000, 1);
    issue(32'h80000000, 2'b00, 32'h80000000, 32'h80000000, 4'b0001, 1);
    issue(32'h7F7FFFFF, 2'b00, 32'h7F7FFFFF, 32'h7F800000, 4'b1000, 1);
    issue(32'h3F800000, 2'b00, 32'h00000001, 32'h3F800000, 4'b0000, 1);
    idle();
    drain();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL add_sub_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_mul();
    issue(32'h41200000, 2'b10, 32'hC1A00000, 32'hC3480000, 4'b0000, 1);
    idle();
    issue(32'hBF800000, 2'b10, 32'hBF800000, 32'h3F800000, 4'b0000, 1);
    issue(32'h7F7FFFFF, 2'b10, 32'h40000000, 32'h7F800000, 4'b1000, 1);
    issue(32'h00800000, 2'b10, 32'h00800000, 32'h00000000, 4'b0101, 1);
    issue(32'h80000000, 2'b10, 32'h00000000, 32'h80000000, 4'b0001, 1);
    idle();
    drain();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL mul_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_specials();
    issue(32'h7F800000, 2'b10, 32'h3F800000, 32'h7F800000, 4'b0000, 1);
    issue(32'h7F800000, 2'b10, 32'h00000000, 32'h7FC00000, 4'b0010, 1);
    issue(32'h7F800000, 2'b00, 32'hFF800000, 32'h7FC00000, 4'b0010, 1);
    issue(32'h7FC00000, 2'b10, 32'h3F800000, 32'h7FC00000, 4'b0010, 1);
    issue(32'h7F800000, 2'b00, 32'h3F800000, 32'h7F800000, 4'b0000, 1);
    issue(32'hFF800000, 2'b01, 32'hFF800000, 32'h7FC00000, 4'b0010, 1);
    idle();
    drain();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL specials_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_rounding();
    issue(32'h3F800000, 2'b00, 32'h33800000, 32'h3F800000, 4'b0000, 1);
    issue(32'h3F800001, 2'b00, 32'h33800000, 32'h3F800002, 4'b0000, 1);
    issue(32'h3F800000, 2'b00, 32'h33C00000, 32'h3F800001, 4'b0000, 1);
    issue(32'h3F800000, 2'b00, 32'h30000000, 32'h3F800000, 4'b0000, 1);
    idle();
    drain();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL rounding_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_back_to_back();
    logic [35:0] snap;
    delivered = 0;
    fork
      begin
        issue(32'h3FC00000, 2'b00, 32'h3FC00000, 32'h40400000, 4'b0000, 0);
        issue(32'h41200000, 2'b10, 32'hC1A00000, 32'hC3480000, 4'b0000, 0);
        issue(32'h40400000, 2'b01, 32'h3F800000, 32'h40000000, 4'b0000, 0);
        issue(32'h40000000, 2'b10, 32'h40000000, 32'h40800000, 4'b0000, 0);
        issue(32'h7F800000, 2'b10, 32'h00000000, 32'h7FC00000, 4'b0010, 0);
        issue(32'h3F800000, 2'b00, 32'hBF800000, 32'h00000000, 4'b0001, 0);
        idle();
      end
      begin
        repeat (4) @(negedge clk);
        out_ready = 1'b0;
        #2;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL stall_out_valid got=%b required=1", out_valid); end
        snap = {result, overflow, underflow, invalid, zero};
        repeat (4) begin
          total++;
          if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready got=%b required=0", in_ready); end
          total++;
          if ({result, overflow, underflow, invalid, zero} !== snap) begin
            bad++;
            $display("FAIL stall_hold got=%h required=%h", {result, overflow, underflow, invalid, zero}, snap);
          end
          @(negedge clk);
          #2;
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
    total++;
    if (delivered !== 6) begin bad++; $display("FAIL b2b_count got=%0d required=6", delivered); end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL b2b_pending got=%0d required=0", sb.size()); end
  endtask

  task automatic test_reset_midflight();
    @(negedge clk);
    out_ready = 1'b0;
    issue(32'h3F800000, 2'b00, 32'h3F800000, 32'h40000000, 4'b0000, 0);
    issue(32'h40000000, 2'b10, 32'h40400000, 32'h40C00000, 4'b0000, 0);
    issue(32'h41200000, 2'b01, 32'h3F800000, 32'h41100000, 4'b0000, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b1) begin bad++; $display("FAIL inflight_out_valid got=%b required=1", out_valid); end
    #1;
    rst = 1'b1;
    #1;
    sb.delete();
    total++;
    if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_out_valid got=%b required=0", out_valid); end
    total++;
    if (result !== 32'h0) begin bad++; $display("FAIL midreset_result got=%h required=00000000", result); end
    total++;
    if ({overflow, underflow, invalid, zero} !== 4'b0000) begin
      bad++; $display("FAIL midreset_flags got=%b required=0000", {overflow, underflow, invalid, zero});
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      total++;
      if (out_valid !== 1'b0) begin bad++; $display("FAIL stale_out_valid got=%b required=0", out_valid); end
    end
    issue(32'h40000000, 2'b10, 32'h40000000, 32'h40800000, 4'b0000, 1);
    idle();
    drain();
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL postreset_pending got=%0d required=0", sb.size()); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; op = 2'b00;
    test_reset();
    test_add_sub();
    test_mul();
    test_specials();
    test_rounding();
    test_back_to_back();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
